// File: rtl/wash_cycle_ctrl.sv
// Washing-machine sequencer: SOAK, WASH, then N x (RINSE, SPIN), DONE, with
// internal per-phase down-counters, lid pause/resume and cancel.
module wash_cycle_ctrl #(
   parameter int CNT_W = 16,
   parameter int REP_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cancel,
   input  logic             lid,
   input  logic             tick,
   input  logic [CNT_W-1:0] soak_time,
   input  logic [CNT_W-1:0] wash_time,
   input  logic [CNT_W-1:0] rinse_time,
   input  logic [CNT_W-1:0] spin_time,
   input  logic [REP_W-1:0] rinse_reps,
   output logic [2:0]       state,
   output logic             soak_en,
   output logic             wash_en,
   output logic             rinse_en,
   output logic             spin_en,
   output logic             door_lock,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] remaining,
   output logic [REP_W-1:0] rinse_left
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SOAK  = 3'd1,
      S_WASH  = 3'd2,
      S_RINSE = 3'd3,
      S_SPIN  = 3'd4,
      S_PAUSE = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t           state_q, state_d;
   state_t           saved_q, saved_d;
   logic             start_q;
   logic             start_edge;
   logic             latch;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [REP_W-1:0] rl_q, rl_d;
   logic [CNT_W-1:0] soak_q, wash_q, rinse_q, spin_q;

   assign start_edge = start & ~start_q;

   always_comb begin
      state_d = state_q;
      saved_d = saved_q;
      cnt_d   = cnt_q;
      rl_d    = rl_q;
      latch   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_edge && !lid && !cancel) begin
               latch   = 1'b1;
               state_d = S_SOAK;
               cnt_d   = soak_time;
               rl_d    = (rinse_reps == '0) ? REP_W'(1) : rinse_reps;
            end
         end
         S_SOAK, S_WASH, S_RINSE, S_SPIN: begin
            if (cancel) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               rl_d    = '0;
            end else if (lid) begin
               // Counter is left untouched so the phase resumes where it stopped.
               state_d = S_PAUSE;
               saved_d = state_q;
            end else if (cnt_q == '0) begin
               case (state_q)
                  S_SOAK: begin
                     state_d = S_WASH;
                     cnt_d   = wash_q;
                  end
                  S_WASH: begin
                     state_d = S_RINSE;
                     cnt_d   = rinse_q;
                  end
                  S_RINSE: begin
                     state_d = S_SPIN;
                     cnt_d   = spin_q;
                  end
                  default: begin
                     rl_d = rl_q - REP_W'(1);
                     if (rl_d != '0) begin
                        state_d = S_RINSE;
                        cnt_d   = rinse_q;
                     end else begin
                        state_d = S_DONE;
                     end
                  end
               endcase
            end else if (tick) begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_PAUSE: begin
            if (cancel) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               rl_d    = '0;
            end else if (start_edge && !lid) begin
               state_d = saved_q;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (cancel) begin
               cnt_d = '0;
               rl_d  = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         saved_q   <= S_IDLE;
         start_q   <= 1'b0;
         cnt_q     <= '0;
         rl_q      <= '0;
         soak_en   <= 1'b0;
         wash_en   <= 1'b0;
         rinse_en  <= 1'b0;
         spin_en   <= 1'b0;
         door_lock <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         saved_q   <= saved_d;
         start_q   <= start;
         cnt_q     <= cnt_d;
         rl_q      <= rl_d;
         // Decoded from next-state so the flags line up with the state code.
         soak_en   <= (state_d == S_SOAK);
         wash_en   <= (state_d == S_WASH);
         rinse_en  <= (state_d == S_RINSE);
         spin_en   <= (state_d == S_SPIN);
         door_lock <= (state_d == S_SOAK) || (state_d == S_WASH) ||
                      (state_d == S_RINSE) || (state_d == S_SPIN);
         busy      <= (state_d != S_IDLE);
         done      <= (state_d == S_DONE);
      end
   end

   // Durations are captured only on a start from IDLE.
   always_ff @(posedge clk) begin
      if (latch) begin
         soak_q  <= soak_time;
         wash_q  <= wash_time;
         rinse_q <= rinse_time;
         spin_q  <= spin_time;
      end
   end

   assign state      = state_q;
   assign remaining  = cnt_q;
   assign rinse_left = rl_q;

endmodule

// File: doc/wash_cycle_ctrl.md
Name: wash_cycle_ctrl

Overview:
Parametrised washing-machine sequencer that replaces external per-phase timer inputs with internal programmable down-counters. It sequences SOAK, WASH, then N × (RINSE, SPIN), and then reports DONE. It supports pause/resume on lid open, cancel from any active state, and start-edge detection. It sits between the front-panel/config registers and the motor/valve drivers, with a shared external tick prescaler.

Parameters:
CNT_W, 16, width of each phase duration and of the phase down-counter
REP_W, 2, width of the rinse-repeat count

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  level; only the rising edge (internally detected) acts
cancel  in  1  level; abort to IDLE
lid  in  1  0 = closed, 1 = open
tick  in  1  one-cycle time-base strobe that decrements the phase counter
soak_time  in  CNT_W  SOAK duration in ticks
wash_time  in  CNT_W  WASH duration in ticks
rinse_time  in  CNT_W  RINSE duration in ticks
spin_time  in  CNT_W  SPIN duration in ticks
rinse_reps  in  REP_W  number of RINSE+SPIN passes (0 treated as 1)
state  out  3  current state code
soak_en, wash_en, rinse_en, spin_en  out  1 each  phase drive enables
door_lock  out  1  1 in SOAK/WASH/RINSE/SPIN
busy  out  1  1 in any state except IDLE
done  out  1  one-cycle completion pulse
remaining  out  CNT_W  current phase counter value
rinse_left  out  REP_W  rinse passes still to run, including the current one

Behaviour:
- Reset: the synchronous reset (rst=1 at the clk edge) clears state to IDLE and zeroes all outputs, the counter, the saved-resume state and the start-edge register. A reset mid-phase aborts that phase with no resume.
- State encoding: IDLE=0, SOAK=1, WASH=2, RINSE=3, SPIN=4, PAUSE=5, DONE=6. Code 7 is illegal and goes to IDLE on the next edge.
- Start edge: start_edge = start & ~start_q, where start_q is the registered start. A start held high never retriggers.
- Priority at each edge: rst > cancel > lid > phase completion > tick decrement.
- IDLE: on start_edge & ~lid & ~cancel:
  - latch all *_time inputs and rinse_left = max(rinse_reps, 1);
  - load counter = soak_time;
  - go to SOAK.
  Config inputs are ignored at all other times.
- Phase timing (SOAK/WASH/RINSE/SPIN):
  - on entry, counter is loaded with the latched duration;
  - each cycle with tick=1 and counter != 0, counter decrements;
  - the phase exits on the edge where counter == 0 is observed, so with tick every cycle a phase lasts duration+1 cycles;
  - duration 0 gives a phase of exactly 1 cycle.
- Transitions:
  - SOAK → WASH
  - WASH → RINSE
  - RINSE → SPIN
  - SPIN exit: rinse_left decrements; if the new value != 0 go to RINSE, else go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Lid open during SOAK/WASH/RINSE/SPIN: next state is PAUSE.
  - The interrupted state is saved.
  - The counter is frozen; tick is ignored.
  - All *_en and door_lock are 0.
- PAUSE: on start_edge & ~lid, return to the saved state with the counter unchanged. cancel goes to IDLE.
- Cancel in any non-IDLE state: IDLE on the next edge, with counter and rinse_left cleared. Cancel in IDLE is a no-op. Cancel with a simultaneous start_edge in IDLE means stay in IDLE.
- Outputs are registered and computed from next-state, so *_en, door_lock, busy and done are valid in the same cycle that state shows the corresponding code (zero lag).
- remaining and rinse_left are the live register values.

Test Plan:
1. soak=2, wash=3, rinse=1, spin=2, reps=1, tick=1 every cycle, start pulse → SOAK 3 cycles, WASH 4, RINSE 2, SPIN 3, DONE 1 (done=1), then IDLE. door_lock=1 throughout the phases.
2. Same config with reps=2 → RINSE, SPIN, RINSE, SPIN, DONE. rinse_left reads 2, 2, 1, 1, then 0 at DONE. reps=0 behaves exactly like reps=1.
3. wash=10 with tick every cycle; at remaining=5 set lid=1 → PAUSE next cycle, remaining holds 5 with wash_en=0 and door_lock=0. Set lid=0 and pulse start → WASH resumes at 5 and exits after 6 more cycles.
4. Cancel asserted in SPIN, and separately in PAUSE → IDLE next edge. All enables, busy, remaining and rinse_left are 0.
5. Start pulse with lid=1 → stays IDLE. Start held high across DONE → no new cycle until start falls and rises again. Config changes mid-WASH do not affect the running durations.
6. rst=1 for one cycle during RINSE with remaining=4 → next edge state=0 and all outputs 0. A following start_edge begins from SOAK with freshly latched values.
